adc_pattern_gen: RTL and testbench

- Synthesizable multi-channel ADC test-pattern source; replaces behavioural bench counters and DDR stimulus loops.
- Sits in front of the acquisition path, muxed ahead of the oscilloscope input stage, driving parallel ADC samples.
- Generates per-channel counter, ramp, triangle, walking-one and PRBS patterns, with valid/ready backpressure and a programmable periodic trigger pulse.

---
 rtl/adc_pattern_gen_pkg.sv | 30 +++
 rtl/adc_pattern_gen_if.sv | 16 +
 rtl/adc_pattern_gen_chn.sv | 99 +++++++++
 rtl/adc_pattern_gen.sv | 95 +++++++++
 tb/tb_adc_pattern_gen.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pattern_gen_pkg.sv
// adc_pattern_pkg: shared definitions for the ADC test-pattern generator.
//   pat_mode_e  - per-channel pattern selector (codes 6 and 7 behave as CONST)
//   PRBS_*      - width and feedback taps of the PRBS15 (x^15 + x^14 + 1) LFSR
//   pat_fmt()   - output format: straight, or invert every bit below the MSB
package adc_pattern_pkg;

    typedef enum logic [2:0] {
        PAT_CONST = 3'd0,
        PAT_UP    = 3'd1,
        PAT_DOWN  = 3'd2,
        PAT_WALK  = 3'd3,
        PAT_PRBS  = 3'd4,
        PAT_TRI   = 3'd5
    } pat_mode_e;

    localparam int PRBS_W      = 15;
    localparam int PRBS_TAP_HI = 14;
    localparam int PRBS_TAP_LO = 13;
    localparam int PAT_MAX_DW  = 16;

    // Works on the widest supported sample; callers slice back to their DW.
    function automatic logic [PAT_MAX_DW-1:0] pat_fmt(input logic [PAT_MAX_DW-1:0] value,
                                                      input logic                  fmt,
                                                      input int                    dw);
        logic [PAT_MAX_DW-1:0] mask;
        mask = (PAT_MAX_DW'(1) << (dw - 1)) - PAT_MAX_DW'(1);
        return fmt ? (value ^ mask) : value;
    endfunction

endpackage

// File: rtl/adc_pattern_gen_if.sv
// adc_pattern_gen_if: sample stream from the pattern generator to the acquisition path.
//   dat     - CHN packed samples, channel n at [DW*n +: DW]
//   dat_vld - sample valid, held with stable data until accepted
//   dat_rdy - downstream ready
// master = generator side, slave = consumer side.
interface adc_pattern_gen_if #(
    parameter int CHN = 4,
    parameter int DW  = 14
) ();
    logic [CHN*DW-1:0] dat;
    logic              dat_vld;
    logic              dat_rdy;

    modport master (output dat, output dat_vld, input dat_rdy);
    modport slave  (input dat, input dat_vld, output dat_rdy);
endinterface

// File: rtl/adc_pattern_gen_chn.sv
// adc_pattern_chn: one channel of the pattern generator.
//   clk_i, rstn_i - sample clock, async active-low reset
//   ld_i          - reload channel state from init_i (priority over adv_i)
//   adv_i         - step the pattern to its next value
//   mode_i        - pattern selector (pat_mode_e code)
//   init_i        - start value / PRBS seed
//   max_i         - wrap/turn value for the counter modes
//   s_o           - current channel state S (unformatted)
module adc_pattern_chn
    import adc_pattern_pkg::*;
#(
    parameter int DW = 14
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          ld_i,
    input  logic          adv_i,
    input  logic [2:0]    mode_i,
    input  logic [DW-1:0] init_i,
    input  logic [DW-1:0] max_i,
    output logic [DW-1:0] s_o
);

    logic [DW-1:0]     r_s;
    logic [PRBS_W-1:0] r_lfsr;
    logic              r_dir;

    logic [DW-1:0]     w_s_nxt;
    logic [PRBS_W-1:0] w_lfsr_nxt;
    logic [PRBS_W-1:0] w_lfsr_step;
    logic [PRBS_W-1:0] w_seed_raw;
    logic [PRBS_W-1:0] w_seed;
    logic              w_dir_nxt;

    assign w_lfsr_step = {r_lfsr[PRBS_W-2:0], r_lfsr[PRBS_TAP_HI] ^ r_lfsr[PRBS_TAP_LO]};
    // A zero seed would lock the LFSR, so it is replaced by 1.
    assign w_seed_raw  = PRBS_W'(init_i);
    assign w_seed      = (w_seed_raw == '0) ? PRBS_W'(1) : w_seed_raw;

    always_comb begin
        w_s_nxt    = r_s;
        w_dir_nxt  = r_dir;
        w_lfsr_nxt = r_lfsr;
        case (mode_i)
            PAT_UP:   w_s_nxt = (r_s >= max_i) ? '0 : r_s + DW'(1);
            PAT_DOWN: w_s_nxt = (r_s == '0 || r_s > max_i) ? max_i : r_s - DW'(1);
            PAT_WALK: w_s_nxt = (r_s == '0) ? DW'(1) : {r_s[DW-2:0], r_s[DW-1]};
            PAT_PRBS: begin
                w_lfsr_nxt = w_lfsr_step;
                w_s_nxt    = DW'(w_lfsr_step);
            end
            PAT_TRI: begin
                // Turning points are emitted once; a state outside [0, max]
                // (after a mid-run max change) is pulled back to max.
                if (max_i == '0) begin
                    w_s_nxt   = '0;
                    w_dir_nxt = 1'b0;
                end else if (!r_dir) begin
                    if (r_s >= max_i) begin
                        w_dir_nxt = 1'b1;
                        w_s_nxt   = (r_s == max_i) ? max_i - DW'(1) : max_i;
                    end else begin
                        w_s_nxt = r_s + DW'(1);
                    end
                end else begin
                    if (r_s == '0) begin
                        w_dir_nxt = 1'b0;
                        w_s_nxt   = DW'(1);
                    end else if (r_s > max_i) begin
                        w_s_nxt = max_i;
                    end else begin
                        w_s_nxt = r_s - DW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s    <= '0;
            r_lfsr <= PRBS_W'(1);
            r_dir  <= 1'b0;
        end else if (ld_i) begin
            // In PRBS mode the first sample is the (possibly forced) seed itself.
            r_s    <= (mode_i == PAT_PRBS) ? DW'(w_seed) : init_i;
            r_lfsr <= w_seed;
            r_dir  <= 1'b0;
        end else if (adv_i) begin
            r_s    <= w_s_nxt;
            r_lfsr <= w_lfsr_nxt;
            r_dir  <= w_dir_nxt;
        end
    end

    assign s_o = r_s;

endmodule

// File: rtl/adc_pattern_gen.sv
// adc_pattern_gen: multi-channel ADC test-pattern source with valid/ready
// backpressure and a programmable periodic trigger.
//   clk_i, rstn_i  - sample clock, async active-low reset
//   cfg_en_i       - generator enable (rising level reloads all channels)
//   sync_i         - single-cycle restart of all channels and the trigger
//   cfg_mode_i     - per-channel mode, channel n at [3n+2:3n]
//   cfg_fmt_i      - per-channel format, 1 = invert bits [DW-2:0]
//   cfg_init_i     - per-channel start value / seed
//   cfg_max_i      - shared wrap/turn value
//   cfg_trg_per_i  - trigger period minus 1, 0 disables the trigger
//   cfg_trg_len_i  - trigger pulse length in cycles
//   dat_if         - sample stream (master side)
//   trg_o          - registered trigger pulse
module adc_pattern_gen
    import adc_pattern_pkg::*;
#(
    parameter int CHN = 4,
    parameter int DW  = 14,
    parameter int TW  = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cfg_en_i,
    input  logic              sync_i,
    input  logic [CHN*3-1:0]  cfg_mode_i,
    input  logic [CHN-1:0]    cfg_fmt_i,
    input  logic [CHN*DW-1:0] cfg_init_i,
    input  logic [DW-1:0]     cfg_max_i,
    input  logic [TW-1:0]     cfg_trg_per_i,
    input  logic [TW-1:0]     cfg_trg_len_i,
    adc_pattern_gen_if.master dat_if,
    output logic              trg_o
);

    logic              r_en;
    logic [CHN*DW-1:0] r_dat;
    logic              r_vld;
    logic              r_trg;
    logic [TW-1:0]     r_cnt;

    logic              w_ld;
    logic              w_adv;
    logic [CHN*DW-1:0] w_dat_nxt;
    logic [DW-1:0]     w_s     [CHN];
    logic [PAT_MAX_DW-1:0] w_fmt16 [CHN];

    assign w_ld  = cfg_en_i && (!r_en || sync_i);
    assign w_adv = cfg_en_i && !w_ld && (!r_vld || dat_if.dat_rdy);

    for (genvar n = 0; n < CHN; n++) begin : g_chn
        adc_pattern_chn #(.DW(DW)) u_chn (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .ld_i   (w_ld),
            .adv_i  (w_adv),
            .mode_i (cfg_mode_i[3*n +: 3]),
            .init_i (cfg_init_i[DW*n +: DW]),
            .max_i  (cfg_max_i),
            .s_o    (w_s[n])
        );
        assign w_fmt16[n]              = pat_fmt(PAT_MAX_DW'(w_s[n]), cfg_fmt_i[n], DW);
        assign w_dat_nxt[DW*n +: DW]   = w_fmt16[n][DW-1:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_en  <= 1'b0;
            r_dat <= '0;
            r_vld <= 1'b0;
            r_trg <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_en <= cfg_en_i;
            if (!cfg_en_i || w_ld) begin
                // Disable freezes the data; reload restarts trigger and stream.
                r_vld <= 1'b0;
                r_trg <= 1'b0;
                r_cnt <= '0;
            end else begin
                // Trigger counter free-runs regardless of backpressure.
                r_cnt <= (r_cnt == cfg_trg_per_i) ? '0 : r_cnt + TW'(1);
                r_trg <= (cfg_trg_per_i != '0) && (r_cnt < cfg_trg_len_i);
                if (w_adv) begin
                    r_dat <= w_dat_nxt;
                    r_vld <= 1'b1;
                end
            end
        end
    end

    assign dat_if.dat     = r_dat;
    assign dat_if.dat_vld = r_vld;
    assign trg_o          = r_trg;

endmodule

// File: tb/tb_adc_pattern_gen.sv
module tb_adc_pattern_gen;

    localparam int CHN  = 4;
    localparam int DW   = 14;
    localparam int TW   = 32;
    localparam int MASK = (1 << DW) - 1;
    localparam int INV  = (1 << (DW - 1)) - 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_en;
    logic              sync;
    logic [CHN*3-1:0]  cfg_mode;
    logic [CHN-1:0]    cfg_fmt;
    logic [CHN*DW-1:0] cfg_init;
    logic [DW-1:0]     cfg_max;
    logic [TW-1:0]     trg_per;
    logic [TW-1:0]     trg_len;
    logic              trg;

    int n_checks = 0;
    int n_fail   = 0;

    adc_pattern_gen_if #(.CHN(CHN), .DW(DW)) dat_if ();

    adc_pattern_gen #(.CHN(CHN), .DW(DW), .TW(TW)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cfg_en_i      (cfg_en),
        .sync_i        (sync),
        .cfg_mode_i    (cfg_mode),
        .cfg_fmt_i     (cfg_fmt),
        .cfg_init_i    (cfg_init),
        .cfg_max_i     (cfg_max),
        .cfg_trg_per_i (trg_per),
        .cfg_trg_len_i (trg_len),
        .dat_if        (dat_if),
        .trg_o         (trg)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ch(input int n);
        return int'(dat_if.dat[DW*n +: DW]);
    endfunction

    function automatic int fmt_v(input int v, input bit f);
        return f ? (v ^ INV) : v;
    endfunction

    task automatic set_chn(input int n, input int mode, input int init);
        cfg_mode[3*n +: 3]  = mode[2:0];
        cfg_init[DW*n +: DW] = init[DW-1:0];
    endtask

    task automatic test_reset();
        rstn = 1'b0; cfg_en = 1'b0; sync = 1'b0; cfg_mode = '0; cfg_fmt = '0;
        cfg_init = '0; cfg_max = '0; trg_per = '0; trg_len = '0; dat_if.dat_rdy = 1'b0;
        #23;
        n_checks++; if (dat_if.dat !== '0) begin n_fail++; $display("FAIL reset_dat: got %0h expected 0", dat_if.dat); end
        n_checks++; if (dat_if.dat_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", dat_if.dat_vld); end
        n_checks++; if (trg !== 1'b0) begin n_fail++; $display("FAIL reset_trg: got %b expected 0", trg); end
    endtask

    task automatic test_up_latency();
        int init [CHN];
        bit f [CHN];
        tick();
        rstn = 1'b1;
        init[0] = 'h0FFE; f[0] = 1'b0;
        set_chn(0, 1, init[0]);
        for (int n = 1; n < CHN; n++) begin
            init[n] = int'($urandom_range(0, MASK));
            f[n]    = 1'($urandom_range(0, 1));
            set_chn(n, (n == 1) ? 0 : (n == 2) ? 7 : 6, init[n]);
            cfg_fmt[n] = f[n];
        end
        cfg_fmt[0] = 1'b0;
        cfg_max = 14'h0FFF;
        dat_if.dat_rdy = 1'b1;
        tick();
        n_checks++; if (dat_if.dat_vld !== 1'b0) begin n_fail++; $display("FAIL up_disabled_vld: got %b expected 0", dat_if.dat_vld); end
        cfg_en = 1'b1;
        tick();
        n_checks++; if (dat_if.dat_vld !== 1'b0) begin n_fail++; $display("FAIL up_first_edge_vld: got %b expected 0", dat_if.dat_vld); end
        tick();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dat_if.dat_vld !== 1'b1) begin n_fail++; $display("FAIL up_vld[%0d]: got %b expected 1", i, dat_if.dat_vld); end
            n_checks++; if (ch(0) !== (init[0] + i) % 'h1000) begin n_fail++; $display("FAIL up_ch0[%0d]: got %0h expected %0h", i, ch(0), (init[0] + i) % 'h1000); end
            for (int n = 1; n < CHN; n++) begin
                n_checks++; if (ch(n) !== fmt_v(init[n], f[n])) begin n_fail++; $display("FAIL const_ch%0d[%0d]: got %0h expected %0h", n, i, ch(n), fmt_v(init[n], f[n])); end
            end
            tick();
        end
    endtask

    task automatic test_modes();
        int walk_init, exp, r, pos;
        int tri_ref [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        walk_init = int'($urandom_range(1, MASK));
        cfg_en = 1'b0;
        tick();
        cfg_max = 14'd3;
        set_chn(0, 2, 2);
        set_chn(1, 5, 0);
        set_chn(2, 3, walk_init);
        set_chn(3, 1, 5);
        for (int f = 0; f < 2; f++) begin
            cfg_fmt = (f != 0) ? '1 : '0;
            cfg_en = 1'b1;
            tick();
            tick();
            for (int k = 0; k < 12; k++) begin
                exp = fmt_v(((2 - k) % 4 + 4) % 4, f[0]);
                n_checks++; if (ch(0) !== exp) begin n_fail++; $display("FAIL down[%0d] fmt%0d: got %0h expected %0h", k, f, ch(0), exp); end
                pos = k % 6;
                exp = fmt_v((pos <= 3) ? pos : 6 - pos, f[0]);
                n_checks++; if (ch(1) !== exp) begin n_fail++; $display("FAIL tri[%0d] fmt%0d: got %0h expected %0h", k, f, ch(1), exp); end
                if (k < 8) begin
                    exp = fmt_v(tri_ref[k], f[0]);
                    n_checks++; if (ch(1) !== exp) begin n_fail++; $display("FAIL tri_table[%0d] fmt%0d: got %0h expected %0h", k, f, ch(1), exp); end
                end
                r = k % DW;
                exp = (r == 0) ? walk_init : (((walk_init << r) | (walk_init >> (DW - r))) & MASK);
                exp = fmt_v(exp, f[0]);
                n_checks++; if (ch(2) !== exp) begin n_fail++; $display("FAIL walk[%0d] fmt%0d: got %0h expected %0h", k, f, ch(2), exp); end
                exp = fmt_v((k == 0) ? 5 : (k - 1) % 4, f[0]);
                n_checks++; if (ch(3) !== exp) begin n_fail++; $display("FAIL up_above_max[%0d] fmt%0d: got %0h expected %0h", k, f, ch(3), exp); end
                tick();
            end
            cfg_en = 1'b0;
            tick();
            n_checks++; if (dat_if.dat_vld !== 1'b0) begin n_fail++; $display("FAIL disable_vld: got %b expected 0", dat_if.dat_vld); end
        end
        cfg_fmt = '0;
    endtask

    task automatic test_prbs();
        int l0, l2, init0, errs, zeros, last, bad_i, bad_got, bad_exp;
        init0 = int'($urandom_range(0, MASK));
        l0 = init0 & 'h7FFF;
        if (l0 == 0) l0 = 1;
        l2 = 1;
        errs = 0; zeros = 0; last = -1; bad_i = -1; bad_got = 0; bad_exp = 0;
        set_chn(0, 4, init0);
        set_chn(1, 0, 'h155);
        set_chn(2, 4, 0);
        set_chn(3, 0, 'h2AA);
        cfg_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i <= 32767; i++) begin
            if (ch(2) !== (l2 & MASK) || ch(0) !== (l0 & MASK) || dat_if.dat_vld !== 1'b1) begin
                errs++;
                if (bad_i < 0) begin bad_i = i; bad_got = ch(2); bad_exp = l2 & MASK; end
            end
            if (i < 32767 && ch(2) == 0) zeros++;
            if (i == 32767) last = ch(2);
            l0 = ((l0 << 1) | (((l0 >> 14) ^ (l0 >> 13)) & 1)) & 'h7FFF;
            l2 = ((l2 << 1) | (((l2 >> 14) ^ (l2 >> 13)) & 1)) & 'h7FFF;
            tick();
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL prbs_seq: got %0d bad samples (first at %0d ch2 %0h) expected 0 (ch2 %0h)", errs, bad_i, bad_got, bad_exp); end
        n_checks++; if (last !== 1) begin n_fail++; $display("FAIL prbs_period: got %0h expected 1", last); end
        n_checks++; if (zeros !== 1) begin n_fail++; $display("FAIL prbs_zero_count: got %0d expected 1", zeros); end
        cfg_en = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int init, mx, acc, prev_d, exp;
        bit prev_vld, prev_rdy, rdy;
        mx   = int'($urandom_range(20, 200));
        init = int'($urandom_range(0, mx));
        cfg_max = mx[DW-1:0];
        set_chn(0, 1, init);
        for (int n = 1; n < CHN; n++) set_chn(n, 0, n);
        dat_if.dat_rdy = 1'b1;
        cfg_en = 1'b1;
        tick();
        tick();
        acc = 0; prev_vld = 1'b0; prev_rdy = 1'b1; prev_d = 0;
        for (int c = 0; c < 80; c++) begin
            if (prev_vld && !prev_rdy) begin
                n_checks++; if (dat_if.dat_vld !== 1'b1 || ch(0) !== prev_d) begin n_fail++; $display("FAIL bp_hold[%0d]: got vld %b dat %0h expected vld 1 dat %0h", c, dat_if.dat_vld, ch(0), prev_d); end
            end
            rdy = (c >= 20 && c < 25) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (dat_if.dat_vld === 1'b1 && rdy) begin
                exp = (init + acc) % (mx + 1);
                n_checks++; if (ch(0) !== exp) begin n_fail++; $display("FAIL bp_seq[%0d]: got %0h expected %0h", acc, ch(0), exp); end
                acc++;
            end
            prev_vld = (dat_if.dat_vld === 1'b1);
            prev_rdy = rdy;
            prev_d   = ch(0);
            dat_if.dat_rdy = rdy;
            tick();
        end
        n_checks++; if (acc < 40) begin n_fail++; $display("FAIL bp_throughput: got %0d accepted expected at least 40", acc); end
        dat_if.dat_rdy = 1'b1;
        cfg_en = 1'b0;
        tick();
    endtask

    task automatic run_trigger(input int per, input int len, input int cycles, input string tag);
        bit exp;
        trg_per = per[TW-1:0];
        trg_len = len[TW-1:0];
        cfg_en = 1'b0;
        tick();
        cfg_en = 1'b1;
        tick();
        n_checks++; if (trg !== 1'b0) begin n_fail++; $display("FAIL %s_ld: got %b expected 0", tag, trg); end
        for (int j = 1; j <= cycles; j++) begin
            tick();
            exp = (per != 0) && (((j - 1) % (per + 1)) < len);
            n_checks++; if (trg !== exp) begin n_fail++; $display("FAIL %s[%0d] per %0d len %0d: got %b expected %b", tag, j, per, len, trg, exp); end
        end
    endtask

    task automatic test_trigger();
        int init;
        int pers [6];
        int lens [6];
        init = int'($urandom_range(0, 1000));
        cfg_max = 14'd1000;
        set_chn(0, 1, init);
        dat_if.dat_rdy = 1'b1;
        run_trigger(9, 3, 35, "trg_9_3");
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n_checks++; if (trg !== 1'b0 || dat_if.dat_vld !== 1'b0) begin n_fail++; $display("FAIL sync_edge: got trg %b vld %b expected 0 0", trg, dat_if.dat_vld); end
        tick();
        n_checks++; if (trg !== 1'b1) begin n_fail++; $display("FAIL sync_trg: got %b expected 1", trg); end
        n_checks++; if (dat_if.dat_vld !== 1'b1 || ch(0) !== init) begin n_fail++; $display("FAIL sync_reload: got vld %b dat %0h expected vld 1 dat %0h", dat_if.dat_vld, ch(0), init); end
        pers = '{0, 5, 3, 1, 0, 0};
        lens = '{3, 0, 9, 1, 0, 0};
        pers[4] = int'($urandom_range(1, 12)); lens[4] = int'($urandom_range(0, 15));
        pers[5] = int'($urandom_range(1, 12)); lens[5] = int'($urandom_range(0, 15));
        for (int t = 0; t < 6; t++) run_trigger(pers[t], lens[t], 30, "trg_cfg");
        cfg_en = 1'b0;
        tick();
        n_checks++; if (trg !== 1'b0) begin n_fail++; $display("FAIL trg_disable: got %b expected 0", trg); end
    endtask

    task automatic test_async_reset();
        int init;
        init = int'($urandom_range(1, 900));
        cfg_max = 14'd1000;
        set_chn(0, 1, init);
        trg_per = 32'd4;
        trg_len = 32'd9;
        cfg_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (trg !== 1'b1 || dat_if.dat_vld !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got trg %b vld %b expected 1 1", trg, dat_if.dat_vld); end
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (dat_if.dat !== '0) begin n_fail++; $display("FAIL async_dat: got %0h expected 0", dat_if.dat); end
        n_checks++; if (dat_if.dat_vld !== 1'b0) begin n_fail++; $display("FAIL async_vld: got %b expected 0", dat_if.dat_vld); end
        n_checks++; if (trg !== 1'b0) begin n_fail++; $display("FAIL async_trg: got %b expected 0", trg); end
        tick();
        tick();
        #3 rstn = 1'b1;
        tick();
        n_checks++; if (dat_if.dat_vld !== 1'b0) begin n_fail++; $display("FAIL rst_release_first_edge: got %b expected 0", dat_if.dat_vld); end
        tick();
        n_checks++; if (dat_if.dat_vld !== 1'b1 || ch(0) !== init) begin n_fail++; $display("FAIL rst_release_reload: got vld %b dat %0h expected vld 1 dat %0h", dat_if.dat_vld, ch(0), init); end
        tick();
        n_checks++; if (ch(0) !== init + 1) begin n_fail++; $display("FAIL rst_release_second: got %0h expected %0h", ch(0), init + 1); end
    endtask

    initial begin
        test_reset();
        test_up_latency();
        test_modes();
        test_prbs();
        test_backpressure();
        test_trigger();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
